// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: fetch FSM states, reset vector and
// architectural constants used by the instruction-fetch stage.
package riscv_pkg;

    typedef enum logic [1:0] {
        FETCH_BOOT    = 2'd0,
        FETCH_RUN     = 2'd1,
        FETCH_WAIT    = 2'd2,
        FETCH_DISCARD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: issues word fetches, holds one presented entry
// for decode, and squashes in-flight or presented work on redirects.
module fetch_ctrl
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus_4,
    output logic [31:0] if_instr
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;

    logic [31:0] r_fetch_pc;
    logic [31:0] r_req_addr;
    logic        r_if_valid_q;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_pc_plus_4;
    logic [31:0] r_if_instr;

    logic        w_xfer;
    logic        w_load;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= FETCH_BOOT;
        else       r_state <= w_state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns the signal and no latch is inferred.
        w_state_next = r_state;
        case (r_state)
            FETCH_BOOT:    w_state_next = FETCH_RUN;
            FETCH_RUN:     if (imem_req && !imem_ack) w_state_next = FETCH_WAIT;
            FETCH_WAIT: begin
                if (imem_ack)            w_state_next = FETCH_RUN;
                else if (redirect_valid) w_state_next = FETCH_DISCARD;
            end
            FETCH_DISCARD: if (imem_ack) w_state_next = FETCH_RUN;
            default:       w_state_next = FETCH_BOOT;
        endcase
    end

    // An outstanding request keeps its captured address even if a redirect
    // moves fetch_pc underneath it.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = r_fetch_pc;
        case (r_state)
            FETCH_RUN:     imem_req = (!r_if_valid_q || id_ready) && !redirect_valid;
            FETCH_WAIT,
            FETCH_DISCARD: begin
                imem_req  = 1'b1;
                imem_addr = r_req_addr;
            end
            default:       imem_req = 1'b0;
        endcase
    end

    assign if_valid = r_if_valid_q && !redirect_valid;
    assign w_xfer   = if_valid && id_ready;
    assign w_load   = imem_req && imem_ack && !redirect_valid &&
                      ((r_state == FETCH_RUN) || (r_state == FETCH_WAIT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc     <= RESET_PC;
            r_req_addr     <= RESET_PC;
            r_if_valid_q   <= 1'b0;
            r_if_pc        <= RESET_PC;
            r_if_pc_plus_4 <= RESET_PC + 32'd4;
            r_if_instr     <= NOP_INSTR;
        end else begin
            if (r_state == FETCH_RUN) r_req_addr <= r_fetch_pc;

            if (redirect_valid) begin
                r_fetch_pc   <= word_align(redirect_pc);
                r_if_valid_q <= 1'b0;
            end else if (w_load) begin
                r_fetch_pc   <= imem_addr + 32'd4;
                r_if_valid_q <= 1'b1;
            end else if (w_xfer) begin
                r_if_valid_q <= 1'b0;
            end

            if (w_load) begin
                r_if_pc        <= imem_addr;
                r_if_pc_plus_4 <= imem_addr + 32'd4;
                r_if_instr     <= imem_rdata;
            end
        end
    end

    assign if_pc        = r_if_pc;
    assign if_pc_plus_4 = r_if_pc_plus_4;
    assign if_instr     = r_if_instr;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed per-cycle vector table, reset
// corner cases, then randomized traffic against a program-order reference model.
module tb_fetch_ctrl;
    import riscv_pkg::*;

    localparam logic L = 1'b0;
    localparam logic H = 1'b1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic        id_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus_4;
    logic [31:0] if_instr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .id_ready       (id_ready),
        .if_pc          (if_pc),
        .if_pc_plus_4   (if_pc_plus_4),
        .if_instr       (if_instr)
    );

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        ack;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    // Instruction memory contents: a fixed function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[17:2]};
    endfunction

    function automatic vec_t mk(input logic redir, input logic [31:0] rpc,
                                input logic rdy, input logic ack,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_pc);
        vec_t v;
        v.redir = redir; v.rpc = rpc; v.rdy = rdy; v.ack = ack;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: drive decode/redirect just after the edge, then the memory
    // response once imem_req/imem_addr have settled.
    task automatic apply(input logic redir, input logic [31:0] rpc,
                         input logic rdy, input logic ack);
        @(posedge clk); #1;
        redirect_valid = redir;
        redirect_pc    = rpc;
        id_ready       = rdy;
        #1;
        imem_ack   = ack;
        imem_rdata = ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   {31'd0, imem_req}, 32'd0);
        check({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
        check({tag, "_pc"},    if_pc, RESET_PC_DEFAULT);
        check({tag, "_pc4"},   if_pc_plus_4, RESET_PC_DEFAULT + 32'd4);
        check({tag, "_instr"}, if_instr, NOP_INSTR);
    endtask

    task automatic check_presented(input string tag, input logic [31:0] pc);
        check({tag, "_pc"},    if_pc, pc);
        check({tag, "_pc4"},   if_pc_plus_4, pc + 32'd4);
        check({tag, "_instr"}, if_instr, mem_word(pc));
    endtask

    initial begin
        logic        pending;
        logic [31:0] pend_addr;
        logic        hold_prev;
        logic [31:0] hold_pc;
        logic [31:0] hold_instr;
        logic [31:0] exp_pc;
        int          n_xfer;

        // Directed table: each row is one cycle after the BOOT cycle.
        vecs.push_back(mk(L, 32'h0,   H, H, H, 32'h000, L, 32'h000));
        vecs.push_back(mk(L, 32'h0,   H, H, H, 32'h004, H, 32'h000));
        vecs.push_back(mk(L, 32'h0,   H, H, H, 32'h008, H, 32'h004));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(L, 32'h0, L, L, L, 32'h0, H, 32'h008));
        vecs.push_back(mk(L, 32'h0,   H, L, H, 32'h00C, H, 32'h008));
        vecs.push_back(mk(L, 32'h0,   H, L, H, 32'h00C, L, 32'h0));
        vecs.push_back(mk(L, 32'h0,   H, H, H, 32'h00C, L, 32'h0));
        vecs.push_back(mk(L, 32'h0,   H, L, H, 32'h010, H, 32'h00C));
        vecs.push_back(mk(L, 32'h0,   H, L, H, 32'h010, L, 32'h0));
        vecs.push_back(mk(L, 32'h0,   H, L, H, 32'h010, L, 32'h0));
        vecs.push_back(mk(L, 32'h0,   H, H, H, 32'h010, L, 32'h0));
        vecs.push_back(mk(L, 32'h0,   H, H, H, 32'h014, H, 32'h010));
        vecs.push_back(mk(H, 32'h40,  H, L, L, 32'h0,   L, 32'h0));
        vecs.push_back(mk(L, 32'h0,   H, H, H, 32'h040, L, 32'h0));
        vecs.push_back(mk(L, 32'h0,   H, L, H, 32'h044, H, 32'h040));
        vecs.push_back(mk(H, 32'h103, H, L, H, 32'h044, L, 32'h0));
        vecs.push_back(mk(L, 32'h0,   H, L, H, 32'h044, L, 32'h0));
        vecs.push_back(mk(L, 32'h0,   H, H, H, 32'h044, L, 32'h0));
        vecs.push_back(mk(L, 32'h0,   H, H, H, 32'h100, L, 32'h0));
        vecs.push_back(mk(L, 32'h0,   L, L, L, 32'h0,   H, 32'h100));
        vecs.push_back(mk(L, 32'h0,   H, L, H, 32'h104, H, 32'h100));
        vecs.push_back(mk(H, 32'h200, H, L, H, 32'h104, L, 32'h0));
        vecs.push_back(mk(H, 32'h302, H, L, H, 32'h104, L, 32'h0));
        vecs.push_back(mk(L, 32'h0,   H, H, H, 32'h104, L, 32'h0));
        vecs.push_back(mk(L, 32'h0,   H, H, H, 32'h300, L, 32'h0));
        vecs.push_back(mk(L, 32'h0,   L, L, L, 32'h0,   H, 32'h300));
        vecs.push_back(mk(L, 32'h0,   H, L, H, 32'h304, H, 32'h300));
        vecs.push_back(mk(H, 32'h500, H, H, H, 32'h304, L, 32'h0));
        vecs.push_back(mk(L, 32'h0,   H, H, H, 32'h500, L, 32'h0));
        vecs.push_back(mk(L, 32'h0,   L, L, L, 32'h0,   H, 32'h500));

        // Reset state, then the BOOT cycle right after release.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        reset = 1'b0;
        #1;
        check("boot_req", {31'd0, imem_req}, 32'd0);

        foreach (vecs[i]) begin
            apply(vecs[i].redir, vecs[i].rpc, vecs[i].rdy, vecs[i].ack);
            check($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
            if (vecs[i].e_req)
                check($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
            check($sformatf("v%0d_valid", i), {31'd0, if_valid}, {31'd0, vecs[i].e_valid});
            if (vecs[i].e_valid)
                check_presented($sformatf("v%0d", i), vecs[i].e_pc);
        end

        // Reset asserted while a request is outstanding in WAIT.
        apply(L, 32'h0, H, L);
        check("wr_req_issue", {31'd0, imem_req}, 32'd1);
        check("wr_addr_issue", imem_addr, 32'h504);
        apply(L, 32'h0, H, L);
        check("wr_req_wait", {31'd0, imem_req}, 32'd1);
        imem_ack = 1'b0;
        reset    = 1'b1;
        #1;
        check_reset_outputs("wr_rst");
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("wr_boot_req", {31'd0, imem_req}, 32'd0);
        apply(L, 32'h0, H, H);
        check("wr_first_req", {31'd0, imem_req}, 32'd1);
        check("wr_first_addr", imem_addr, RESET_PC_DEFAULT);
        apply(L, 32'h0, H, L);
        check("wr_first_valid", {31'd0, if_valid}, 32'd1);
        check_presented("wr_first", RESET_PC_DEFAULT);

        // Randomized traffic: decode must see the program-order stream, with
        // every redirect restarting it at the aligned target.
        imem_ack = 1'b0;
        redirect_valid = 1'b0;
        id_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        pending   = 1'b0;
        pend_addr = 32'h0;
        hold_prev = 1'b0;
        hold_pc   = 32'h0;
        hold_instr = 32'h0;
        exp_pc    = RESET_PC_DEFAULT;
        n_xfer    = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            redirect_valid = ($urandom_range(0, 99) < 8);
            redirect_pc    = $urandom();
            id_ready       = ($urandom_range(0, 99) < 70);
            #1;
            if (pending) begin
                check("rnd_req_hold", {31'd0, imem_req}, 32'd1);
                check("rnd_addr_hold", imem_addr, pend_addr);
            end
            if (imem_req)
                check("rnd_addr_align", imem_addr & 32'h3, 32'h0);
            imem_ack   = imem_req && ($urandom_range(0, 99) < 55);
            imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom();
            #1;
            if (redirect_valid)
                check("rnd_valid_in_redirect", {31'd0, if_valid}, 32'd0);
            if (hold_prev) begin
                check("rnd_hold_pc", if_pc, hold_pc);
                check("rnd_hold_instr", if_instr, hold_instr);
                if (!redirect_valid)
                    check("rnd_hold_valid", {31'd0, if_valid}, 32'd1);
            end
            if (if_valid && id_ready) begin
                check_presented("rnd_xfer", exp_pc);
                exp_pc = exp_pc + 32'd4;
                n_xfer++;
            end
            if (redirect_valid)
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
            pending    = imem_req && !imem_ack;
            pend_addr  = imem_addr;
            hold_prev  = if_valid && !id_ready;
            hold_pc    = if_pc;
            hold_instr = if_instr;
        end
        check("rnd_progress", {31'd0, n_xfer > 300}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, shall set the first fetch address after reset.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high.
REQ-004 redirect_valid  input  1  one-cycle branch/jump redirect request from execute.
REQ-005 redirect_pc  input  32  redirect target; bits [1:0] shall be ignored and treated as 0.
REQ-006 imem_req  output  1  instruction-memory request.
REQ-007 imem_addr  output  32  word-aligned fetch address.
REQ-008 imem_ack  input  1  memory completion, same cycle as valid imem_rdata; zero or more wait cycles.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 if_valid  output  1  instruction available to decode.
REQ-011 id_ready  input  1  decode accepts this cycle; transfer = if_valid && id_ready.
REQ-012 if_pc, if_pc_plus_4, if_instr  output  32 each  PC, PC+4 and instruction of the presented entry.

Function
REQ-013 States shall be BOOT, RUN, WAIT, DISCARD; internal fetch_pc holds the next address to fetch.
REQ-014 BOOT shall last exactly one cycle after reset release, with imem_req=0, then go to RUN.
REQ-015 In RUN, imem_req shall be (!if_valid_q || id_ready) && !redirect_valid, with imem_addr = fetch_pc.
REQ-016 In RUN, on imem_req && imem_ack: load if_instr=imem_rdata, if_pc=fetch_pc, if_pc_plus_4=fetch_pc+4, set if_valid_q, set fetch_pc += 4 (modulo 2^32), stay in RUN.
REQ-017 In RUN, on imem_req && !imem_ack, the FSM shall go to WAIT.
REQ-018 In WAIT and DISCARD, imem_req shall stay 1 and imem_addr stable until imem_ack, regardless of id_ready.
REQ-019 In WAIT, on imem_ack without redirect, the output register shall load as in REQ-016, and the FSM shall return to RUN.
REQ-020 if_valid_q shall clear on a transfer that is not replaced by a same-cycle load.
REQ-021 if_valid shall equal if_valid_q && !redirect_valid, so an entry presented during a redirect is never transferred.
REQ-022 A redirect in any state shall:
- clear if_valid_q;
- set fetch_pc = {redirect_pc[31:2],2'b00};
- take effect for the next request.
REQ-023 A redirect in WAIT without imem_ack shall move the FSM to DISCARD; with imem_ack the returned data shall be dropped and the FSM shall go to RUN.
REQ-024 DISCARD shall drop the returned data on imem_ack and go to RUN; a further redirect in DISCARD shall overwrite fetch_pc (latest wins).
REQ-025 Output registers shall hold their values while if_valid && !id_ready; the block shall never lose or duplicate an instruction.
REQ-026 Throughput shall be one instruction per cycle with zero-wait memory and id_ready=1; fetch latency from request to if_valid shall be one cycle.

Reset
REQ-027 Reset shall force:
- state=BOOT, fetch_pc=RESET_PC, if_valid_q=0;
- if_pc=RESET_PC, if_pc_plus_4=RESET_PC+4, if_instr=32'h0000_0013 (NOP);
- imem_req=0.
REQ-028 Reset asserted with a request outstanding shall abandon it; the memory side shall also be reset.

Structure
REQ-029 The state enum, RESET_PC default and NOP constant shall live in the shared package riscv_pkg.
REQ-030 The block shall be a single module with no sub-module; the output register and FSM shall be local.

Verification
REQ-031 Reset release, zero-wait memory, id_ready=1 -> first imem_req in cycle 2 with addr 0; addresses 0,4,8,... per cycle; if_pc follows one cycle later.
REQ-032 Memory ack delayed 3 cycles at addr 0x10 -> imem_req/addr held 4 cycles; if_valid rises one cycle after ack with if_pc=0x10.
REQ-033 id_ready=0 for 5 cycles while if_valid=1 (if_pc=0x8) -> no imem_req, outputs stable; first request after release is addr 0xC.
REQ-034 Redirect to 0x103 in WAIT two cycles before ack -> DISCARD, ack data dropped, next request addr 0x100, if_valid low until then.
REQ-035 Redirect to 0x40 with if_valid=1 and id_ready=1 in the same cycle -> no transfer, next presented if_pc=0x40.
REQ-036 Reset asserted mid-WAIT -> outputs return to reset values immediately, fetch restarts at RESET_PC.
